sram_prog_bridge: RTL

//  Byte-wide SRAM controller for the 16-bit external SRAM, in two modes. In run mode it passes

---
 rtl/sram_prog_bridge_pkg.sv | 24 ++
 rtl/sram_prog_bridge_sync_edge.sv | 40 ++++
 rtl/sram_prog_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_prog_bridge_pkg.sv
// Shared definitions for the SRAM programming bridge: loader FSM states,
// header size limits and the byte-lane select helper.
package sram_prog_bridge_pkg;

   typedef enum logic [1:0] {
      ST_ADDR = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } prog_state_e;

   localparam int HDR_MIN = 1;
   localparam int HDR_MAX = 4;

   // Even byte addresses live in the upper lane of the 16-bit word.
   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic a0);
      if (a0 == 1'b0) begin
         return word[15:8];
      end else begin
         return word[7:0];
      end
   endfunction

endpackage

// File: rtl/sram_prog_bridge_sync_edge.sv
// Two-flop synchroniser for a slow-domain level flag, followed by a registered
// one-cycle pulse on its rising edge.
module sync_edge (
   input  logic clock4,
   input  logic resetn,
   input  logic din,
   output logic pulse
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic pulse_q, pulse_d;

   // Next-state: shift the flag through the chain and detect 0->1.
   always_comb begin
      meta_d  = din;
      sync_d  = meta_q;
      prev_d  = sync_q;
      pulse_d = sync_q & ~prev_q;
   end

   // Synchroniser and edge registers.
   always_ff @(posedge clock4 or negedge resetn) begin
      if (!resetn) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/sram_prog_bridge.sv
// Byte-wide controller for the 16-bit SRAM: registered CPU pass-through in run
// mode, framed UART loader (address, length, payload, checksum) in prog mode.
module sram_prog_bridge
   import sram_prog_bridge_pkg::*;
#(
   parameter int CPU_AW    = 16,
   parameter int RAM_AW    = 19,
   parameter int HDR_BYTES = 4,
   parameter int TIMEOUT   = 400000
) (
   input  logic              clock4,
   input  logic              resetn,
   input  logic [CPU_AW-1:0] cpu_address,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   input  logic              cpu_load,
   input  logic              cpu_store,
   input  logic              prog,
   input  logic [7:0]        rx_data,
   input  logic              rx_flag,
   output logic              prog_busy,
   output logic              prog_done,
   output logic              prog_err,
   output logic [RAM_AW-1:0] prog_count,
   output logic [RAM_AW-2:0] SRAM_A,
   inout  wire  [15:0]       SRAM_D,
   output logic              SRAM_CE_n,
   output logic              SRAM_OE_n,
   output logic              SRAM_WE_n,
   output logic              SRAM_UB_n,
   output logic              SRAM_LB_n
);

   if (HDR_BYTES < HDR_MIN || HDR_BYTES > HDR_MAX) begin : g_bad_hdr
      $error("HDR_BYTES out of range");
   end

   localparam logic [1:0]        IDX_LAST = 2'(HDR_BYTES - 1);
   localparam logic [RAM_AW-1:0] ONE      = RAM_AW'(1);

   logic rx_stb;

   sync_edge u_rx_sync (
      .clock4 (clock4),
      .resetn (resetn),
      .din    (rx_flag),
      .pulse  (rx_stb)
   );

   prog_state_e       state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [RAM_AW-1:0] paddr_q, paddr_d;
   logic [RAM_AW-1:0] len_q, len_d;
   logic [RAM_AW-1:0] count_q, count_d;
   logic [7:0]        sum_q, sum_d;
   logic [31:0]       timer_q, timer_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [RAM_AW-1:0] pin_addr_q, pin_addr_d;
   logic [7:0]        pin_wdata_q, pin_wdata_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;

   logic              busy_s, timeout_s, prog_wr_s;
   logic [RAM_AW-1:0] hdr_base_s, hdr_shift_s;

   assign busy_s    = (state_q != ST_ADDR) || (idx_q != 2'd0);
   assign timeout_s = (TIMEOUT != 0) && busy_s && (timer_q == 32'(TIMEOUT));
   assign prog_wr_s = prog && !timeout_s && rx_stb && (state_q == ST_DATA);

   // Header bytes shift in MSB first; the first byte of a field starts it afresh.
   assign hdr_base_s  = (state_q == ST_LEN) ? len_q : paddr_q;
   assign hdr_shift_s = (idx_q == 2'd0) ? RAM_AW'(rx_data)
                                        : {hdr_base_s[RAM_AW-9:0], rx_data};

   // Loader FSM, checksum, status and inter-byte timeout.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      paddr_d = paddr_q;
      len_d   = len_q;
      count_d = count_q;
      sum_d   = sum_q;
      err_d   = err_q;
      done_d  = 1'b0;
      timer_d = (busy_s && !rx_stb) ? timer_q + 32'd1 : 32'd0;

      if (!prog) begin
         state_d = ST_ADDR;
         idx_d   = 2'd0;
         sum_d   = 8'd0;
         timer_d = 32'd0;
      end else if (timeout_s) begin
         // A byte landing with the timeout is discarded.
         err_d   = 1'b1;
         state_d = ST_ADDR;
         idx_d   = 2'd0;
         sum_d   = 8'd0;
         timer_d = 32'd0;
      end else if (rx_stb) begin
         case (state_q)
            ST_ADDR: begin
               paddr_d = hdr_shift_s;
               err_d   = (idx_q == 2'd0) ? 1'b0 : err_q;
               count_d = (idx_q == 2'd0) ? {RAM_AW{1'b0}} : count_q;
               if (idx_q == IDX_LAST) begin
                  idx_d   = 2'd0;
                  state_d = ST_LEN;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            ST_LEN: begin
               len_d = hdr_shift_s;
               if (idx_q == IDX_LAST) begin
                  idx_d   = 2'd0;
                  state_d = (hdr_shift_s == {RAM_AW{1'b0}}) ? ST_CSUM : ST_DATA;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            ST_DATA: begin
               paddr_d = paddr_q + ONE;
               len_d   = len_q - ONE;
               sum_d   = sum_q + rx_data;
               count_d = count_q + ONE;
               state_d = (len_q == ONE) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
               done_d  = (rx_data == sum_q);
               err_d   = (rx_data != sum_q);
               state_d = ST_ADDR;
               idx_d   = 2'd0;
               sum_d   = 8'd0;
            end
            default: begin
               state_d = ST_ADDR;
               idx_d   = 2'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Pin register stage: CPU request in run mode, loader write strobe in prog mode.
   always_comb begin
      pin_addr_d  = pin_addr_q;
      pin_wdata_d = pin_wdata_q;
      we_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      if (!prog) begin
         pin_addr_d  = RAM_AW'(cpu_address);
         pin_wdata_d = cpu_wdata;
         we_n_d      = ~cpu_store;
         oe_n_d      = ~(cpu_load & ~cpu_store);
      end else if (prog_wr_s) begin
         pin_addr_d  = paddr_q;
         pin_wdata_d = rx_data;
         we_n_d      = 1'b0;
      end else begin
         we_n_d = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clock4 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_ADDR;
         idx_q       <= 2'd0;
         paddr_q     <= {RAM_AW{1'b0}};
         len_q       <= {RAM_AW{1'b0}};
         count_q     <= {RAM_AW{1'b0}};
         sum_q       <= 8'd0;
         timer_q     <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pin_addr_q  <= {RAM_AW{1'b0}};
         pin_wdata_q <= 8'd0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         paddr_q     <= paddr_d;
         len_q       <= len_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         timer_q     <= timer_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pin_addr_q  <= pin_addr_d;
         pin_wdata_q <= pin_wdata_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
      end
   end

   assign prog_busy  = busy_s;
   assign prog_done  = done_q;
   assign prog_err   = err_q;
   assign prog_count = count_q;

   assign SRAM_A    = pin_addr_q[RAM_AW-1:1];
   assign SRAM_D    = we_n_q ? {16{1'bz}} : {pin_wdata_q, pin_wdata_q};
   assign SRAM_CE_n = 1'b0;
   assign SRAM_OE_n = oe_n_q;
   assign SRAM_WE_n = we_n_q;
   assign SRAM_UB_n = pin_addr_q[0];
   assign SRAM_LB_n = ~pin_addr_q[0];
   assign cpu_rdata = lane_byte(SRAM_D, pin_addr_q[0]);

endmodule
